// File: rtl/harvard_data_bridge.sv
// Stalls the CPU data port while a single Avalon-MM style transfer completes.
// Optional watchdog: define HARVARD_DATA_BRIDGE_TIMEOUT_EN to abort stuck transfers and raise bus_error.
module harvard_data_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        ext_clk_enable,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_write,
  input  logic        cpu_data_read,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        opWrite_q;
  logic        dual_q;
  logic        memRead_q;
  logic        memWrite_q;
  logic        request;
  logic        timeoutHit;

  assign request = cpu_data_read | cpu_data_write;

`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] waitCnt_q;
  logic [CntW-1:0] waitCnt_d;
  logic            busError_q;

  assign waitCnt_d  = waitCnt_q + CntW'(1);
  assign timeoutHit = (state_q == ACCESS) & mem_waitrequest & (waitCnt_d == CntW'(TIMEOUT_CYCLES));

  // Watchdog counts stalled ACCESS cycles; bus_error stays set until reset.
  always_ff @(posedge clk) begin
    if (resetl) begin
      waitCnt_q  <= '0;
      busError_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && request) begin
        waitCnt_q <= '0;
      end else if ((state_q == ACCESS) && mem_waitrequest) begin
        waitCnt_q <= waitCnt_d;
      end
      if (timeoutHit) begin
        busError_q <= 1'b1;
      end
    end
  end

  assign bus_error = busError_q;
`else
  logic unusedTimeout;

  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign timeoutHit    = 1'b0;
  assign bus_error     = 1'b0;
`endif

  // A simultaneous read+write is carried out as a write that leaves zero as the read result.
  always_ff @(posedge clk) begin
    if (resetl) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      opWrite_q  <= 1'b0;
      dual_q     <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request) begin
            addr_q     <= cpu_data_address;
            wdata_q    <= cpu_data_writedata;
            opWrite_q  <= cpu_data_write;
            dual_q     <= cpu_data_read & cpu_data_write;
            memRead_q  <= ~cpu_data_write;
            memWrite_q <= cpu_data_write;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_waitrequest) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            if (!opWrite_q) begin
              rdata_q <= mem_readdata;
            end else if (dual_q) begin
              rdata_q <= '0;
            end
            state_q <= DONE;
          end else if (timeoutHit) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            if (!opWrite_q) begin
              rdata_q <= 32'hDEADBEEF;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          if (ext_clk_enable) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The CPU may only advance when no request is pending in IDLE, or once the result is ready.
  assign cpu_clk_enable = ~resetl & ext_clk_enable &
                          (((state_q == IDLE) & ~request) | (state_q == DONE));

  assign cpu_data_readdata = rdata_q;
  assign mem_address       = addr_q;
  assign mem_writedata     = wdata_q;
  assign mem_read          = memRead_q;
  assign mem_write         = memWrite_q;

endmodule

// File: tb/tb_harvard_data_bridge.sv
// Self-checking bench for harvard_data_bridge: transaction-level latency model plus literal pins.
// Follows HARVARD_DATA_BRIDGE_TIMEOUT_EN the same way the design does.
module tb_harvard_data_bridge;

  localparam int unsigned TimeoutCycles = 4;

  logic        clk = 1'b0;
  logic        resetl = 1'b1;
  logic        ext_clk_enable = 1'b0;
  logic        cpu_clk_enable;
  logic [31:0] cpu_data_address = '0;
  logic        cpu_data_write = 1'b0;
  logic        cpu_data_read = 1'b0;
  logic [31:0] cpu_data_writedata = '0;
  logic [31:0] cpu_data_readdata;
  logic [31:0] mem_address;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  // Expectations for the current cycle, written by the driver and consumed by the compare process.
  logic        expValid = 1'b0;
  logic        expCke = 1'b0;
  logic        expRd = 1'b0;
  logic        expWr = 1'b0;
  logic [31:0] expAddr = '0;
  logic [31:0] expWdata = '0;

  // Architectural model: last read result and sticky error flag.
  logic [31:0] mRdata = '0;
  logic        mBusErr = 1'b0;

  logic [15:0] ckeTrace = '0;
  int          memRdCycles = 0;
  int          memWrCycles = 0;

  always #5 clk = ~clk;

  harvard_data_bridge #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk               (clk),
    .resetl            (resetl),
    .ext_clk_enable    (ext_clk_enable),
    .cpu_clk_enable    (cpu_clk_enable),
    .cpu_data_address  (cpu_data_address),
    .cpu_data_write    (cpu_data_write),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata (cpu_data_readdata),
    .mem_address       (mem_address),
    .mem_write         (mem_write),
    .mem_read          (mem_read),
    .mem_writedata     (mem_writedata),
    .mem_readdata      (mem_readdata),
    .mem_waitrequest   (mem_waitrequest),
    .bus_error         (bus_error)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every checked cycle, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("cpu_clk_enable", 32'(cpu_clk_enable), 32'(expCke));
      checkOutput("mem_read", 32'(mem_read), 32'(expRd));
      checkOutput("mem_write", 32'(mem_write), 32'(expWr));
      checkOutput("cpu_data_readdata", cpu_data_readdata, mRdata);
      checkOutput("bus_error", 32'(bus_error), 32'(mBusErr));
      if (expRd || expWr) begin
        checkOutput("mem_address", mem_address, expAddr);
      end
      if (expWr) begin
        checkOutput("mem_writedata", mem_writedata, expWdata);
      end
    end
    ckeTrace = {ckeTrace[14:0], cpu_clk_enable};
    if (mem_read) memRdCycles++;
    if (mem_write) memWrCycles++;
  end

  // One clock cycle: drive inputs just after the rising edge, then let the compare process sample.
  task automatic applyStimulus(input logic rst, input logic rd, input logic wr, input logic ext,
                               input logic wreq, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] mrd, input logic chk, input logic eCke,
                               input logic eRd, input logic eWr);
    @(posedge clk);
    #1;
    resetl             = rst;
    cpu_data_read      = rd;
    cpu_data_write     = wr;
    ext_clk_enable     = ext;
    mem_waitrequest    = wreq;
    cpu_data_address   = addr;
    cpu_data_writedata = wd;
    mem_readdata       = mrd;
    expValid           = chk;
    expCke             = eCke;
    expRd              = eRd;
    expWr              = eWr;
    expAddr            = addr;
    expWdata           = wd;
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic ext);
    applyStimulus(1'b0, 1'b0, 1'b0, ext, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, ext, 1'b0, 1'b0);
  endtask

  // Request cycle, waits+1 access cycles (or the watchdog limit), holdDone stalled DONE cycles, release.
  task automatic doTxn(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int waits, input logic [31:0] mrd, input int holdDone);
    logic isRd;
    logic isWr;
    logic abort;
    int   accessCycles;
    isWr         = wr;
    isRd         = rd & ~wr;
    abort        = 1'b0;
    accessCycles = waits + 1;
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
    if (waits >= int'(TimeoutCycles)) begin
      abort        = 1'b1;
      accessCycles = int'(TimeoutCycles);
    end
`endif
    memRdCycles = 0;
    memWrCycles = 0;
    applyStimulus(1'b0, rd, wr, 1'b1, 1'b0, addr, wd, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < accessCycles; k++) begin
      applyStimulus(1'b0, rd, wr, 1'b1, (k < waits), addr, wd,
                    (k == waits) ? mrd : (32'hBAD00000 + 32'(k)), 1'b1, 1'b0, isRd, isWr);
    end
    if (abort) begin
      if (isRd) mRdata = 32'hDEADBEEF;
      mBusErr = 1'b1;
    end else if (isRd) begin
      mRdata = mrd;
    end else if (rd) begin
      mRdata = 32'h0;
    end
    for (int h = 0; h < holdDone; h++) begin
      applyStimulus(1'b0, rd, wr, 1'b0, 1'b0, addr, wd, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, rd, wr, 1'b1, 1'b0, addr, wd, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset: first cycle unchecked (outputs not yet defined), second checked.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resetReaddata", cpu_data_readdata, 32'h0);
    checkOutput("resetCke", 32'(cpu_clk_enable), 32'h0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    idleCycle(1'b1);

    // Zero-wait read.
    doTxn(1'b1, 1'b0, 32'h0000_1000, 32'h0, 0, 32'h1234_5678, 0);
    checkOutput("readReaddata", cpu_data_readdata, 32'h1234_5678);
    checkOutput("readMemReadCycles", 32'(memRdCycles), 32'd1);
    checkOutput("readCkeTrace", 32'(ckeTrace[2:0]), 32'h1);
    idleCycle(1'b1);

    // Write with three wait cycles.
    doTxn(1'b0, 1'b1, 32'h0000_2004, 32'hCAFE_F00D, 3, 32'h0, 0);
    checkOutput("writeMemWriteCycles", 32'(memWrCycles), 32'd4);
    checkOutput("writeCkeTrace", 32'(ckeTrace[5:0]), 32'h01);
    checkOutput("writeKeepsReaddata", cpu_data_readdata, 32'h1234_5678);
    idleCycle(1'b1);

    // Read and write together: write only, zero result.
    doTxn(1'b1, 1'b1, 32'h0000_3008, 32'h1111_2222, 1, 32'h5555_AAAA, 0);
    checkOutput("dualMemReadCycles", 32'(memRdCycles), 32'd0);
    checkOutput("dualMemWriteCycles", 32'(memWrCycles), 32'd2);
    checkOutput("dualReaddata", cpu_data_readdata, 32'h0);
    idleCycle(1'b1);

    // Read whose DONE is stretched by two disabled cycles.
    doTxn(1'b1, 1'b0, 32'h0000_4000, 32'h0, 0, 32'hA5A5_A5A5, 2);
    checkOutput("holdCkeTrace", 32'(ckeTrace[4:0]), 32'h01);
    checkOutput("holdReaddata", cpu_data_readdata, 32'hA5A5_A5A5);

    // Back-to-back: unaligned read then write, no idle gap.
    doTxn(1'b1, 1'b0, 32'h0000_5001, 32'h0, 2, 32'h0BAD_F00D, 0);
    doTxn(1'b0, 1'b1, 32'h0000_5003, 32'h8765_4321, 0, 32'h0, 0);
    checkOutput("b2bReaddata", cpu_data_readdata, 32'h0BAD_F00D);
    idleCycle(1'b1);

    // Long stall: aborted by the watchdog when enabled, otherwise waited out.
    doTxn(1'b1, 1'b0, 32'h0000_6000, 32'h0, 12, 32'h7654_3210, 0);
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
    checkOutput("timeoutReaddata", cpu_data_readdata, 32'hDEAD_BEEF);
    checkOutput("timeoutBusError", 32'(bus_error), 32'h1);
`else
    checkOutput("longWaitReaddata", cpu_data_readdata, 32'h7654_3210);
    checkOutput("longWaitBusError", 32'(bus_error), 32'h0);
`endif
    doTxn(1'b0, 1'b1, 32'h0000_7000, 32'h0F0F_0F0F, 0, 32'h0, 0);
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
    checkOutput("stickyBusError", 32'(bus_error), 32'h1);
`else
    checkOutput("quietBusError", 32'(bus_error), 32'h0);
`endif
    idleCycle(1'b1);

    // Reset while a read is stalled in ACCESS.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_8000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_8000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    mRdata  = 32'h0;
    mBusErr = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_8000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("midResetMemRead", 32'(mem_read), 32'h0);
    checkOutput("midResetReaddata", cpu_data_readdata, 32'h0);
    idleCycle(1'b1);
    idleCycle(1'b1);

    // Recovery after reset.
    doTxn(1'b1, 1'b0, 32'h0000_9000, 32'h0, 1, 32'h600D_F00D, 0);
    checkOutput("recoverReaddata", cpu_data_readdata, 32'h600D_F00D);
    idleCycle(1'b1);

    expValid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
